// File: rtl/zap_dram_responder.sv
// zap_dram_responder
// Memory-side responder for the ZAP simple D-memory bus. Requests are serviced
// from an internal word-addressed RAM after RD_WAIT/WR_WAIT wait states.
// The block signals completion by dropping o_stall for one ACK cycle.
//
// Ports:
//   i_clk, i_reset_n     clock, asynchronous active-low reset
//   i_rd_en, i_wr_en     read / write request, held while o_stall is high
//   i_addr[31:0]         byte address; the word index is i_addr[31:2]
//   i_data[31:0]         write data
//   i_ben[3:0]           write byte enables (bit n covers bits [8n+7:8n])
//   o_data[31:0]         registered read data, held until the next read completes
//   o_stall              combinational busy indication
//   o_err                registered, high in the ACK cycle of an erroneous access
module zap_dram_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned RD_WAIT     = 2,
  parameter int unsigned WR_WAIT     = 1
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_rd_en,
  input  logic        i_wr_en,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_data,
  input  logic [3:0]  i_ben,
  output logic [31:0] o_data,
  output logic        o_stall,
  output logic        o_err
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] ACK  = 2'd2;

  localparam logic [3:0]  RD_W    = 4'(RD_WAIT);
  localparam logic [3:0]  WR_W    = 4'(WR_WAIT);
  localparam logic [29:0] DEPTH_L = 30'(DEPTH_WORDS);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [29:0] waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  ben_q, ben_d;
  logic        wr_q, wr_d;
  logic        both_q, both_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem [0:DEPTH_WORDS-1];

  logic        req;
  logic [3:0]  req_wait;
  logic [29:0] acc_addr;
  logic [31:0] acc_data;
  logic [3:0]  acc_ben;
  logic        acc_wr;
  logic        acc_both;
  logic        acc_in_range;
  logic        do_access;
  logic        mem_we;
  logic [31:0] mem_rd;
  logic [31:0] mem_wr_word;
  logic        unused_addr_lsb;

  assign unused_addr_lsb = ^i_addr[1:0];

  assign req      = i_rd_en | i_wr_en;
  assign req_wait = i_wr_en ? WR_W : RD_W;

  // Zero-wait accesses complete on the very edge that samples the request, so
  // the access operands come straight from the inputs in IDLE and from the
  // latched copies in BUSY.
  always_comb begin
    acc_addr = waddr_q;
    acc_data = wdata_q;
    acc_ben  = ben_q;
    acc_wr   = wr_q;
    acc_both = both_q;
    if (state_q == IDLE) begin
      acc_addr = i_addr[31:2];
      acc_data = i_data;
      acc_ben  = i_ben;
      acc_wr   = i_wr_en;
      acc_both = i_rd_en & i_wr_en;
    end
  end

  assign acc_in_range = (acc_addr < DEPTH_L);
  assign do_access    = ((state_q == IDLE) && req && (req_wait == 4'd0)) ||
                        ((state_q == BUSY) && (cnt_q == 4'd1));
  assign mem_rd       = mem[acc_addr[AW-1:0]];
  assign mem_we       = do_access & acc_wr & acc_in_range & i_reset_n;

  always_comb begin
    mem_wr_word = mem_rd;
    for (int unsigned n = 0; n < 4; n++) begin
      if (acc_ben[n]) mem_wr_word[8*n +: 8] = acc_data[8*n +: 8];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    ben_d   = ben_q;
    wr_d    = wr_q;
    both_d  = both_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (req) begin
          waddr_d = i_addr[31:2];
          wdata_d = i_data;
          ben_d   = i_ben;
          wr_d    = i_wr_en;
          both_d  = i_rd_en & i_wr_en;
          if (req_wait == 4'd0) begin
            state_d = ACK;
          end else begin
            cnt_d   = req_wait;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (cnt_q == 4'd1) begin
          cnt_d   = '0;
          state_d = ACK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (do_access) begin
      err_d = acc_both | ~acc_in_range;
      if (!acc_wr) rdata_d = acc_in_range ? mem_rd : '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      ben_q   <= '0;
      wr_q    <= 1'b0;
      both_q  <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      ben_q   <= ben_d;
      wr_q    <= wr_d;
      both_q  <= both_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // RAM contents are deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (mem_we) mem[acc_addr[AW-1:0]] <= mem_wr_word;
  end

  assign o_stall = i_reset_n & (((state_q == IDLE) & req) | (state_q == BUSY));
  assign o_data  = rdata_q;
  assign o_err   = err_q;

endmodule
